// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one uart_tx byte stream between NUM_REQ requesters.
// A grant lasts until a last-flagged beat or MAX_BURST beats, then one IDLE cycle re-arbitrates.
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned MAX_BURST  = 16
) (
   input  logic                          CLK,
   input  logic                          RSTN,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
   input  logic [NUM_REQ-1:0]            req_last_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   output logic [DATA_WIDTH-1:0]         tx_data_o,
   output logic                          tx_valid_o,
   input  logic                          tx_ready_i,
   output logic [NUM_REQ-1:0]            grant_o,
   output logic                          busy_o
);

   localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [0:0] {StIdle, StStream} state_e;

   state_e              state_q, state_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic [IdxW-1:0]     idx_q, idx_d;
   logic [IdxW-1:0]     ptr_q, ptr_d;
   logic [7:0]          cnt_q, cnt_d;

   int unsigned         cand;
   logic [IdxW-1:0]     cand_idx;
   logic                found;
   logic [IdxW-1:0]     win_idx;
   logic                beat;

   // Search starts one past the last winner so the previous owner gets lowest priority.
   always_comb begin
      cand     = 0;
      cand_idx = '0;
      found    = 1'b0;
      win_idx  = '0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         cand     = (32'(ptr_q) + i) % NUM_REQ;
         cand_idx = IdxW'(cand);
         if (!found && req_valid_i[cand_idx]) begin
            found   = 1'b1;
            win_idx = cand_idx;
         end
      end
   end

   always_comb begin
      tx_valid_o  = 1'b0;
      tx_data_o   = '0;
      req_ready_o = '0;
      if (state_q == StStream) begin
         tx_valid_o         = req_valid_i[idx_q];
         tx_data_o          = req_data_i[idx_q*DATA_WIDTH +: DATA_WIDTH];
         req_ready_o[idx_q] = tx_ready_i;
      end
   end

   assign beat    = (state_q == StStream) && tx_valid_o && tx_ready_i;
   assign grant_o = grant_q;
   assign busy_o  = (state_q == StStream);

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (found) begin
               state_d          = StStream;
               grant_d          = '0;
               grant_d[win_idx] = 1'b1;
               idx_d            = win_idx;
               ptr_d            = win_idx;
               cnt_d            = '0;
            end
         end
         StStream: begin
            if (beat) begin
               if (req_last_i[idx_q] || (cnt_q == 8'(MAX_BURST - 1))) begin
                  state_d = StIdle;
                  grant_d = '0;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q <= StIdle;
         grant_q <= '0;
         idx_q   <= '0;
         ptr_q   <= IdxW'(NUM_REQ - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-requester byte queues feed the DUT, a scoreboard
// queue holds the expected {grant, byte} sequence and a negedge monitor checks every beat.
module tb_uart_tx_arbiter;

   localparam int unsigned NR = 4;
   localparam int unsigned DW = 8;
   localparam int unsigned MB = 16;

   logic              CLK = 1'b0;
   logic              RSTN;
   logic [NR-1:0]     req_valid_i;
   logic [NR*DW-1:0]  req_data_i;
   logic [NR-1:0]     req_last_i;
   logic [NR-1:0]     req_ready_o;
   logic [DW-1:0]     tx_data_o;
   logic              tx_valid_o;
   logic              tx_ready_i;
   logic [NR-1:0]     grant_o;
   logic              busy_o;

   int                total = 0;
   int                bad   = 0;
   logic [11:0]       sb[$];
   logic [11:0]       sb_e;
   logic [8:0]        mem [NR][64];
   int                head [NR];
   int                tail [NR];
   logic [NR-1:0]     mask = '0;
   logic [NR-1:0]     acc  = '0;

   uart_tx_arbiter #(
      .NUM_REQ    (NR),
      .DATA_WIDTH (DW),
      .MAX_BURST  (MB)
   ) dut (
      .CLK         (CLK),
      .RSTN        (RSTN),
      .req_valid_i (req_valid_i),
      .req_data_i  (req_data_i),
      .req_last_i  (req_last_i),
      .req_ready_o (req_ready_o),
      .tx_data_o   (tx_data_o),
      .tx_valid_o  (tx_valid_o),
      .tx_ready_i  (tx_ready_i),
      .grant_o     (grant_o),
      .busy_o      (busy_o)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic add(input int r, input logic [7:0] d, input logic last);
      mem[r][tail[r]] = {last, d};
      tail[r]++;
   endtask

   task automatic expect_beat(input int r, input logic [7:0] d);
      logic [NR-1:0] g;
      g    = '0;
      g[r] = 1'b1;
      sb.push_back({g, d});
   endtask

   // Packet of n bytes base, base+1, ... with last on the final byte, expected in that order.
   task automatic pkt(input int r, input logic [7:0] base, input int n);
      for (int k = 0; k < n; k++) begin
         add(r, base + 8'(k), (k == n - 1));
         expect_beat(r, base + 8'(k));
      end
   endtask

   function automatic bit pending();
      for (int i = 0; i < NR; i++) if (head[i] < tail[i]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic drive();
      req_valid_i = '0;
      req_last_i  = '0;
      req_data_i  = '0;
      for (int i = 0; i < NR; i++) begin
         if (head[i] < tail[i] && !mask[i]) begin
            req_valid_i[i]          = 1'b1;
            req_data_i[i*DW +: DW]  = mem[i][head[i]][7:0];
            req_last_i[i]           = mem[i][head[i]][8];
         end
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
      for (int i = 0; i < NR; i++) if (acc[i]) head[i]++;
      drive();
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((busy_o || pending()) && n < 300) begin
         tick();
         n++;
      end
      check(name, (n < 300), 1);
   endtask

   always @(negedge CLK) acc = req_ready_o & req_valid_i;

   always @(negedge CLK) begin
      if (RSTN && tx_valid_o && tx_ready_i) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_extra: got beat %0h grant %0h want none", tx_data_o, grant_o);
         end else begin
            sb_e = sb.pop_front();
            check("sb_beat", {20'd0, grant_o, tx_data_o}, {20'd0, sb_e});
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      RSTN       = 1'b0;
      tx_ready_i = 1'b1;
      for (int i = 0; i < NR; i++) begin
         head[i] = 0;
         tail[i] = 0;
      end

      // Reset with every requester valid, then requester 0 must win first.
      pkt(0, 8'hA0, 1);
      pkt(1, 8'hB0, 1);
      pkt(2, 8'hC0, 1);
      pkt(3, 8'hD0, 1);
      drive();
      repeat (2) @(negedge CLK);
      check("rst_grant", grant_o, 0);
      check("rst_txvalid", tx_valid_o, 0);
      check("rst_ready", req_ready_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_data", tx_data_o, 0);
      @(posedge CLK);
      #1;
      RSTN = 1'b1;
      tick();
      @(negedge CLK);
      check("first_grant", grant_o, 4'b0001);
      drain("drain_reset");

      // Single 3-byte packet from requester 2 on consecutive cycles.
      pkt(2, 8'h41, 3);
      drive();
      tick();
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         check("sp_grant", grant_o, 4'b0100);
         check("sp_data", tx_data_o, 8'h41 + k);
         tick();
      end
      @(negedge CLK);
      check("sp_idle_grant", grant_o, 0);
      check("sp_idle_busy", busy_o, 0);

      // Round-robin 0,1,2,3,0 with 2-byte packets: 3 cycles per grant.
      RSTN = 1'b0;
      tick();
      RSTN = 1'b1;
      pkt(0, 8'h10, 2);
      pkt(1, 8'h20, 2);
      pkt(2, 8'h30, 2);
      pkt(3, 8'h40, 2);
      pkt(0, 8'h18, 2);
      drive();
      repeat (14) tick();
      check("rr_busy_last", busy_o, 1);
      tick();
      check("rr_busy_end", busy_o, 0);
      check("rr_empty", pending(), 0);

      // Backpressure: 10 stalled cycles hold the second byte.
      pkt(1, 8'h11, 3);
      drive();
      tick();
      tick();
      tx_ready_i = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge CLK);
         check("bp_data", tx_data_o, 8'h12);
         check("bp_valid", tx_valid_o, 1);
         check("bp_ready", req_ready_o, 0);
         tick();
      end
      tx_ready_i = 1'b1;
      drain("drain_bp");

      // Burst limit: requester 1 releases after 16 beats, requester 3 then gets a turn.
      for (int k = 0; k < 20; k++) add(1, 8'h80 + 8'(k), (k == 19));
      for (int k = 0; k < 16; k++) expect_beat(1, 8'h80 + 8'(k));
      expect_beat(3, 8'hE0);
      expect_beat(3, 8'hE1);
      for (int k = 16; k < 20; k++) expect_beat(1, 8'h80 + 8'(k));
      drive();
      tick();
      add(3, 8'hE0, 1'b0);
      add(3, 8'hE1, 1'b1);
      drive();
      @(negedge CLK);
      check("bl_grant1", grant_o, 4'b0010);
      repeat (16) tick();
      check("bl_release", busy_o, 0);
      tick();
      check("bl_grant3", grant_o, 4'b1000);
      drain("drain_bl");

      // Valid gap holds the grant; reset mid-packet clears outputs asynchronously.
      add(0, 8'h50, 1'b0);
      add(0, 8'h51, 1'b0);
      add(0, 8'h52, 1'b0);
      add(0, 8'h53, 1'b1);
      expect_beat(0, 8'h50);
      expect_beat(0, 8'h51);
      drive();
      tick();
      tick();
      mask[0] = 1'b1;
      drive();
      for (int k = 0; k < 5; k++) begin
         @(negedge CLK);
         check("gap_grant", grant_o, 4'b0001);
         check("gap_valid", tx_valid_o, 0);
         check("gap_busy", busy_o, 1);
         tick();
      end
      mask[0] = 1'b0;
      drive();
      tick();
      check("mid_valid_pre", tx_valid_o, 1);
      #2;
      RSTN = 1'b0;
      #1;
      check("mid_grant", grant_o, 0);
      check("mid_busy", busy_o, 0);
      check("mid_valid", tx_valid_o, 0);
      check("mid_ready", req_ready_o, 0);
      check("mid_data", tx_data_o, 0);
      for (int i = 0; i < NR; i++) head[i] = tail[i];
      drive();
      tick();
      tick();
      RSTN = 1'b1;
      tick();
      check("sb_empty", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
